// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: PC select encodings,
// controller states and a saturating counter helper.
package fetch_pkg;

  localparam logic [1:0] PCSEL_RST  = 2'd0;
  localparam logic [1:0] PCSEL_HOLD = 2'd1;
  localparam logic [1:0] PCSEL_PC4  = 2'd2;
  localparam logic [1:0] PCSEL_ALU  = 2'd3;

  localparam logic [3:0] BOOT_WEA = 4'hF;

  typedef enum logic [1:0] {
    RST_VEC = 2'd0,
    BOOT    = 2'd1,
    RUN     = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_wr_arb.sv
// IMEM port-A write arbiter: picks between CPU stores and boot-loader writes
// and registers the winning write onto the IMEM port for exactly one cycle.
module fetch_wr_arb
  import fetch_pkg::*;
#(
  parameter int IMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boot_phase,
  input  logic               run_phase,
  input  logic               cpu_wr_valid,
  input  logic [IMEM_AW-1:0] cpu_wr_addr,
  input  logic [31:0]        cpu_wr_data,
  input  logic [3:0]         cpu_wr_be,
  input  logic               boot_valid,
  input  logic [IMEM_AW-1:0] boot_addr,
  input  logic [31:0]        boot_data,
  output logic               boot_ready,
  output logic               wr_accept,
  output logic [3:0]         imem_wea,
  output logic [IMEM_AW-1:0] imem_addra,
  output logic [31:0]        imem_dina,
  output logic [15:0]        boot_wr_cnt
);

  logic cpu_take;

  // CPU stores only count in RUN; during BOOT the CPU is ignored entirely.
  assign cpu_take   = run_phase & cpu_wr_valid;
  assign boot_ready = boot_valid & (boot_phase | (run_phase & ~cpu_wr_valid));
  assign wr_accept  = cpu_take | boot_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_wea    <= '0;
      imem_addra  <= '0;
      imem_dina   <= '0;
      boot_wr_cnt <= '0;
    end else begin
      if (cpu_take) begin
        imem_wea   <= cpu_wr_be;
        imem_addra <= cpu_wr_addr;
        imem_dina  <= cpu_wr_data;
      end else if (boot_ready) begin
        imem_wea   <= BOOT_WEA;
        imem_addra <= boot_addr;
        imem_dina  <= boot_data;
      end else begin
        imem_wea <= '0;
      end
      if (boot_ready) begin
        boot_wr_cnt <= sat_inc16(boot_wr_cnt);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: reset-vector/boot/run sequencing, PC select and
// post-write fetch hold. Boot-loader support is enabled by FETCH_CTRL_BOOT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int IMEM_AW = 14,
  parameter int WR_HOLD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               should_br,
  input  logic               cpu_wr_valid,
  input  logic [IMEM_AW-1:0] cpu_wr_addr,
  input  logic [31:0]        cpu_wr_data,
  input  logic [3:0]         cpu_wr_be,
  input  logic               boot_valid,
  input  logic [IMEM_AW-1:0] boot_addr,
  input  logic [31:0]        boot_data,
  input  logic               boot_done,
  output logic               boot_ready,
  output logic [1:0]         PC_sel,
  output logic [3:0]         imem_wea,
  output logic [IMEM_AW-1:0] imem_addra,
  output logic [31:0]        imem_dina,
  output logic               fetch_stall,
  output logic [15:0]        boot_wr_cnt
);

`ifdef FETCH_CTRL_BOOT_EN
  localparam logic BOOT_EN = 1'b1;
`else
  localparam logic BOOT_EN = 1'b0;
`endif

  localparam logic [3:0] HOLD_LOAD = 4'(WR_HOLD);

  fetch_state_t state, state_nxt;
  logic [3:0]   hold_cnt;
  logic         wr_accept;
  logic         boot_req;
  logic         boot_phase;
  logic         run_phase;

  assign boot_req   = boot_valid & BOOT_EN;
  assign boot_phase = (state == BOOT);
  assign run_phase  = (state == RUN);

  fetch_wr_arb #(
    .IMEM_AW(IMEM_AW)
  ) u_wr_arb (
    .clk          (clk),
    .rst          (rst),
    .boot_phase   (boot_phase),
    .run_phase    (run_phase),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_be    (cpu_wr_be),
    .boot_valid   (boot_req),
    .boot_addr    (boot_addr),
    .boot_data    (boot_data),
    .boot_ready   (boot_ready),
    .wr_accept    (wr_accept),
    .imem_wea     (imem_wea),
    .imem_addra   (imem_addra),
    .imem_dina    (imem_dina),
    .boot_wr_cnt  (boot_wr_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RST_VEC;
    end else begin
      state <= state_nxt;
    end
  end

  // A branch overrides the hold for its cycle only; the counter keeps running.
  always_comb begin
    state_nxt = state;
    PC_sel    = PCSEL_RST;
    case (state)
      RST_VEC: state_nxt = BOOT_EN ? BOOT : RUN;
      BOOT: begin
        PC_sel = PCSEL_HOLD;
        if (boot_done) state_nxt = RUN;
      end
      RUN: begin
        if (should_br)                           PC_sel = PCSEL_ALU;
        else if ((hold_cnt != 4'd0) || wr_accept) PC_sel = PCSEL_HOLD;
        else                                     PC_sel = PCSEL_PC4;
      end
      default: state_nxt = RST_VEC;
    endcase
  end

  assign fetch_stall = (PC_sel == PCSEL_HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (run_phase && wr_accept) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != 4'd0) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model; adapts to FETCH_CTRL_BOOT_EN.
module tb_fetch_ctrl;

  localparam int AW      = 14;
  localparam int WR_HOLD = 2;

`ifdef FETCH_CTRL_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          should_br;
  logic          cpu_wr_valid;
  logic [AW-1:0] cpu_wr_addr;
  logic [31:0]   cpu_wr_data;
  logic [3:0]    cpu_wr_be;
  logic          boot_valid;
  logic [AW-1:0] boot_addr;
  logic [31:0]   boot_data;
  logic          boot_done;
  logic          boot_ready;
  logic [1:0]    PC_sel;
  logic [3:0]    imem_wea;
  logic [AW-1:0] imem_addra;
  logic [31:0]   imem_dina;
  logic          fetch_stall;
  logic [15:0]   boot_wr_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .IMEM_AW(AW),
    .WR_HOLD(WR_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .should_br    (should_br),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_be    (cpu_wr_be),
    .boot_valid   (boot_valid),
    .boot_addr    (boot_addr),
    .boot_data    (boot_data),
    .boot_done    (boot_done),
    .boot_ready   (boot_ready),
    .PC_sel       (PC_sel),
    .imem_wea     (imem_wea),
    .imem_addra   (imem_addra),
    .imem_dina    (imem_dina),
    .fetch_stall  (fetch_stall),
    .boot_wr_cnt  (boot_wr_cnt)
  );

  // Reference model: phase 0 = reset vector, 1 = boot, 2 = run.
  int            m_phase;
  int            m_hold;
  int            m_cnt;
  logic [3:0]    m_wea;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  int            e_pc;
  bit            e_ready;
  bit            e_cpu;

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_cnt = 0;
    m_wea = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic predict();
    e_cpu   = (m_phase == 2) && cpu_wr_valid;
    e_ready = BOOT_EN && boot_valid && ((m_phase == 1) || ((m_phase == 2) && !cpu_wr_valid));
    if (m_phase == 0)                       e_pc = 0;
    else if (m_phase == 1)                  e_pc = 1;
    else if (should_br)                     e_pc = 3;
    else if (m_hold > 0 || e_cpu || e_ready) e_pc = 1;
    else                                    e_pc = 2;
  endtask

  task automatic model_clock();
    predict();
    if (e_cpu) begin
      m_wea = cpu_wr_be; m_addr = cpu_wr_addr; m_data = cpu_wr_data;
    end else if (e_ready) begin
      m_wea = 4'hF; m_addr = boot_addr; m_data = boot_data;
    end else begin
      m_wea = 4'h0;
    end
    if (e_ready && m_cnt < 65535) m_cnt++;
    if (m_phase == 2 && (e_cpu || e_ready)) m_hold = WR_HOLD;
    else if (m_hold > 0)                    m_hold--;
    if (m_phase == 0)                       m_phase = BOOT_EN ? 1 : 2;
    else if (m_phase == 1 && boot_done)     m_phase = 2;
  endtask

  task automatic idle_inputs();
    should_br = 0; cpu_wr_valid = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_wr_be = '0; boot_valid = 0; boot_addr = '0; boot_data = '0; boot_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic enter_run();
    reset_dut();
    boot_done = 1;
    tick();
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    should_br = 1; cpu_wr_valid = 1; cpu_wr_be = 4'hF; boot_valid = 1; boot_done = 1;
    cpu_wr_addr = AW'($urandom); cpu_wr_data = $urandom; boot_addr = AW'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (PC_sel !== 2'd0) $display("[TB] FAIL reset_pc_sel got %0d exp 0", PC_sel); else passed++;
    checks++; if (imem_wea !== 4'h0) $display("[TB] FAIL reset_wea got %h exp 0", imem_wea); else passed++;
    checks++; if (imem_addra !== '0) $display("[TB] FAIL reset_addra got %h exp 0", imem_addra); else passed++;
    checks++; if (imem_dina !== '0) $display("[TB] FAIL reset_dina got %h exp 0", imem_dina); else passed++;
    checks++; if (boot_ready !== 1'b0) $display("[TB] FAIL reset_boot_ready got %b exp 0", boot_ready); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("[TB] FAIL reset_stall got %b exp 0", fetch_stall); else passed++;
    checks++; if (boot_wr_cnt !== 16'd0) $display("[TB] FAIL reset_cnt got %0d exp 0", boot_wr_cnt); else passed++;
  endtask

  task automatic test_boot_sequence();
    int exp_pc[5];
`ifdef FETCH_CTRL_BOOT_EN
    exp_pc = '{0, 1, 1, 1, 2};
`else
    exp_pc = '{0, 2, 2, 2, 2};
`endif
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      boot_done = (c == 3);
      @(negedge clk);
      checks++;
      if (PC_sel !== 2'(exp_pc[c]))
        $display("[TB] FAIL boot_seq_pc_sel cyc=%0d got %0d exp %0d", c, PC_sel, exp_pc[c]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_boot_write();
    logic [3:0]    exp_wea;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    exp_wea  = BOOT_EN ? 4'hF : 4'h0;
    exp_addr = BOOT_EN ? AW'(16'h0010) : '0;
    exp_data = BOOT_EN ? 32'hDEADBEEF : 32'h0;
    reset_dut();
    tick();
    boot_valid = 1; boot_addr = AW'(16'h0010); boot_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (boot_ready !== BOOT_EN) $display("[TB] FAIL boot_wr_ready got %b exp %b", boot_ready, BOOT_EN); else passed++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (imem_wea !== exp_wea) $display("[TB] FAIL boot_wr_wea got %h exp %h", imem_wea, exp_wea); else passed++;
    checks++; if (imem_addra !== exp_addr) $display("[TB] FAIL boot_wr_addra got %h exp %h", imem_addra, exp_addr); else passed++;
    checks++; if (imem_dina !== exp_data) $display("[TB] FAIL boot_wr_dina got %h exp %h", imem_dina, exp_data); else passed++;
    checks++; if (boot_wr_cnt !== 16'(BOOT_EN)) $display("[TB] FAIL boot_wr_cnt got %0d exp %0d", boot_wr_cnt, BOOT_EN); else passed++;
    tick();
    @(negedge clk);
    checks++; if (imem_wea !== 4'h0) $display("[TB] FAIL boot_wr_single_pulse got %h exp 0", imem_wea); else passed++;
  endtask

  task automatic test_priority();
    logic [AW-1:0] a;
    logic [31:0]   d;
    enter_run();
    a = AW'($urandom); d = $urandom;
    cpu_wr_valid = 1; cpu_wr_be = 4'b0011; cpu_wr_addr = a; cpu_wr_data = d;
    boot_valid = 1; boot_addr = ~a; boot_data = ~d;
    @(negedge clk);
    checks++; if (boot_ready !== 1'b0) $display("[TB] FAIL prio_boot_ready got %b exp 0", boot_ready); else passed++;
    checks++; if (PC_sel !== 2'd1) $display("[TB] FAIL prio_pc_sel got %0d exp 1", PC_sel); else passed++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (imem_wea !== 4'b0011) $display("[TB] FAIL prio_wea got %h exp 3", imem_wea); else passed++;
    checks++; if (imem_addra !== a) $display("[TB] FAIL prio_addra got %h exp %h", imem_addra, a); else passed++;
    checks++; if (imem_dina !== d) $display("[TB] FAIL prio_dina got %h exp %h", imem_dina, d); else passed++;
    checks++; if (boot_wr_cnt !== 16'd0) $display("[TB] FAIL prio_cnt got %0d exp 0", boot_wr_cnt); else passed++;
  endtask

  task automatic test_hold_branch();
    int exp_plain[4] = '{1, 1, 1, 2};
    int exp_br[4]    = '{1, 3, 1, 2};
    for (int pass = 0; pass < 2; pass++) begin
      enter_run();
      for (int c = 0; c < 4; c++) begin
        idle_inputs();
        if (c == 0) begin
          cpu_wr_valid = 1; cpu_wr_be = 4'(1 + $urandom_range(0, 14));
          cpu_wr_addr = AW'($urandom); cpu_wr_data = $urandom;
        end
        if (c == 1 && pass == 1) should_br = 1;
        @(negedge clk);
        checks++;
        if (PC_sel !== 2'(pass == 0 ? exp_plain[c] : exp_br[c]))
          $display("[TB] FAIL hold_pc_sel br=%0d cyc=N+%0d got %0d exp %0d", pass, c, PC_sel,
                   pass == 0 ? exp_plain[c] : exp_br[c]);
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_write();
    enter_run();
    cpu_wr_valid = 1; cpu_wr_be = 4'hF; cpu_wr_addr = AW'($urandom); cpu_wr_data = $urandom;
    @(negedge clk);
    checks++; if (PC_sel !== 2'd1) $display("[TB] FAIL rstw_pc_sel got %0d exp 1", PC_sel); else passed++;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    checks++; if (imem_wea !== 4'h0) $display("[TB] FAIL rstw_wea_in_reset got %h exp 0", imem_wea); else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (imem_wea !== 4'h0) $display("[TB] FAIL rstw_wea cyc=%0d got %h exp 0", c, imem_wea); else passed++;
      if (c == 0) begin
        checks++; if (PC_sel !== 2'd0) $display("[TB] FAIL rstw_rst_vec got %0d exp 0", PC_sel); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      should_br    = ($urandom_range(0, 3) == 0);
      cpu_wr_valid = ($urandom_range(0, 4) == 0);
      cpu_wr_be    = 4'($urandom);
      cpu_wr_addr  = AW'($urandom);
      cpu_wr_data  = $urandom;
      boot_valid   = ($urandom_range(0, 2) == 0);
      boot_addr    = AW'($urandom);
      boot_data    = $urandom;
      boot_done    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      predict();
      checks++; if (PC_sel !== 2'(e_pc)) $display("[TB] FAIL rnd_pc_sel i=%0d got %0d exp %0d", i, PC_sel, e_pc); else passed++;
      checks++; if (fetch_stall !== (e_pc == 1)) $display("[TB] FAIL rnd_stall i=%0d got %b exp %b", i, fetch_stall, e_pc == 1); else passed++;
      checks++; if (boot_ready !== e_ready) $display("[TB] FAIL rnd_boot_ready i=%0d got %b exp %b", i, boot_ready, e_ready); else passed++;
      checks++; if (imem_wea !== m_wea) $display("[TB] FAIL rnd_wea i=%0d got %h exp %h", i, imem_wea, m_wea); else passed++;
      checks++; if (imem_addra !== m_addr) $display("[TB] FAIL rnd_addra i=%0d got %h exp %h", i, imem_addra, m_addr); else passed++;
      checks++; if (imem_dina !== m_data) $display("[TB] FAIL rnd_dina i=%0d got %h exp %h", i, imem_dina, m_data); else passed++;
      checks++; if (boot_wr_cnt !== 16'(m_cnt)) $display("[TB] FAIL rnd_cnt i=%0d got %0d exp %0d", i, boot_wr_cnt, m_cnt); else passed++;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_boot_sequence();
    test_boot_write();
    test_priority();
    test_hold_branch();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
